instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, address of the first instruction fetched after reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: imem_req  output  1  instruction memory read request.
REQ-005 Port: imem_addr  output  16  instruction memory word address.
REQ-006 Port: imem_ack  input  1  memory response strobe; imem_rdata valid in the same cycle.
REQ-007 Port: imem_rdata  input  18  instruction word from memory.
REQ-008 Port: instr  output  18  held instruction to the control decoder.
REQ-009 Port: instr_valid  output  1  instr is valid and not yet consumed.
REQ-010 Port: instr_ready  input  1  decode/execute accepts instr this cycle.
REQ-011 Port: pc_out  output  16  address of the held instruction.
REQ-012 Port: pc_plus1  output  16  pc_out+1 mod 2^16; CALL return address.
REQ-013 Port: redirect  input  1  taken CALL/RET/Jcc; discard the current fetch stream.
REQ-014 Port: redirect_addr  input  16  target address, sampled when redirect=1.

Function
REQ-015 The block SHALL implement states IDLE, FETCH, HOLD and FLUSH; all outputs SHALL be registered or decoded from the state only.
REQ-016 The block SHALL keep internal registers pc (next address to fetch) and fetch_addr (address of the outstanding request); imem_addr SHALL equal fetch_addr.
REQ-017 imem_req SHALL be 1 exactly in FETCH and FLUSH; imem_req and imem_addr SHALL stay stable until the cycle imem_ack=1.
REQ-018 IDLE: the block SHALL go to FETCH on the next edge with fetch_addr<=pc.
REQ-019 FETCH, imem_ack=1, redirect=0: the block SHALL set instr<=imem_rdata and pc_out<=fetch_addr, and go to HOLD; instr_valid SHALL be 1 the next cycle (ack-to-valid latency 1 cycle).
REQ-020 FETCH, imem_ack=0: the block SHALL remain in FETCH; an unbounded wait is legal.
REQ-021 HOLD: instr_valid SHALL be 1; instr and pc_out SHALL remain stable while instr_ready=0.
REQ-022 HOLD, instr_ready=1, redirect=0: the block SHALL set pc<=pc_out+1 (wrapping 16'hFFFF to 16'h0000) and fetch_addr<=pc_out+1, and go to FETCH.
REQ-023 Redirect SHALL have priority over instr_ready and imem_ack in every state.
REQ-024 Redirect in HOLD: the block SHALL drop the held instruction (instr_valid=0 next cycle), load pc and fetch_addr with redirect_addr, and go to FETCH.
REQ-025 Redirect in FETCH with imem_ack=1: the block SHALL discard imem_rdata, load pc and fetch_addr with redirect_addr, and stay in FETCH.
REQ-026 Redirect in FETCH with imem_ack=0: the block SHALL load pc<=redirect_addr, keep fetch_addr, and go to FLUSH.
REQ-027 FLUSH: the block SHALL wait for imem_ack, discard that data, then set fetch_addr<=pc and go to FETCH; a further redirect in FLUSH SHALL overwrite pc only (last one wins).
REQ-028 Redirect in IDLE: the block SHALL load pc<=redirect_addr before the first fetch.
REQ-029 instr_valid SHALL be 0 in IDLE, FETCH and FLUSH; a discarded response SHALL never raise instr_valid.
REQ-030 Throughput SHALL be at most one instruction per 2 cycles with zero-wait memory.

Reset
REQ-031 When rst_n=0, the block SHALL immediately, without a clock edge, enter IDLE with pc=RESET_PC, fetch_addr=RESET_PC, imem_req=0, instr_valid=0, instr=18'h00000, pc_out=16'h0000.
REQ-032 Reset asserted mid-FETCH or mid-FLUSH SHALL abandon the request; the memory is also reset.

Verification
REQ-033 Release reset with zero-wait memory, word 0 = 18'h01234 -> imem_req=1 with addr 0 on cycle 1; on cycle 2 instr_valid=1, instr=18'h01234, pc_out=0, pc_plus1=1; with instr_ready=1, the next request is to addr 1.
REQ-034 Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr, pc_out and instr_valid stay stable, and imem_req=0 throughout.
REQ-035 Redirect to 16'h0040 in HOLD with instr_ready=1 -> instruction not consumed, instr_valid=0 next cycle, next request to addr 16'h0040.
REQ-036 Redirect to 16'h0100 in FETCH (addr 5) with ack 3 cycles later -> imem_addr stays 5 until ack, that data is dropped, then a request to 16'h0100 follows; exactly one instr_valid pulse, carrying the 16'h0100 word.
REQ-037 Wrap: accept the instruction at 16'hFFFF -> pc_plus1=16'h0000 and the next request is to addr 16'h0000.
REQ-038 Assert rst_n=0 mid-FETCH between clock edges -> imem_req and instr_valid drop to 0 at once; after release, the first request is to RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch front end: one outstanding memory read, one held instruction for decode.
// Latency: request on the cycle after reset or accept; instr_valid one cycle after imem_ack.
// Backpressure: instr_ready=0 holds instr/pc_out and stops fetching; redirect overrides it in every state.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata    instruction memory read handshake (data valid with ack)
//   instr/instr_valid/ready    held instruction towards the control decoder
//   pc_out, pc_plus1           address of the held instruction and its successor
//   redirect, redirect_addr    taken control transfer; restart fetching at redirect_addr
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [17:0] imem_rdata,
  output logic [17:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus1,
  input  logic        redirect,
  input  logic [15:0] redirect_addr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  logic [1:0]  state;
  logic [15:0] pc;          // next address to fetch
  logic [15:0] fetch_addr;  // address of the outstanding request

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      instr      <= 18'h00000;
      pc_out     <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (redirect) begin
            pc         <= redirect_addr;
            fetch_addr <= redirect_addr;
          end else begin
            fetch_addr <= pc;
          end
        end
        FETCH: begin
          if (redirect) begin
            pc <= redirect_addr;
            // With the response in hand the old request is finished and the
            // new one can go out at once; otherwise the request must stay
            // stable until its ack, so park in FLUSH to swallow it.
            if (imem_ack) fetch_addr <= redirect_addr;
            else          state      <= FLUSH;
          end else if (imem_ack) begin
            instr  <= imem_rdata;
            pc_out <= fetch_addr;
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc         <= redirect_addr;
            fetch_addr <= redirect_addr;
            state      <= FETCH;
          end else if (instr_ready) begin
            pc         <= pc_plus1;
            fetch_addr <= pc_plus1;
            state      <= FETCH;
          end
        end
        FLUSH: begin
          if (redirect) pc <= redirect_addr;
          if (imem_ack) begin
            // A redirect arriving with the stale ack is the latest target.
            fetch_addr <= redirect ? redirect_addr : pc;
            state      <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_req    = (state == FETCH) || (state == FLUSH);
  assign imem_addr   = fetch_addr;
  assign instr_valid = (state == HOLD);
  assign pc_plus1    = pc_out + 16'd1;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [17:0] imem_rdata;
  logic [17:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] pc_out;
  logic [15:0] pc_plus1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_addr = 16'h0000;
  logic        ack_en = 1'b1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Memory contents: word 0 is fixed, every other word is a function of its address.
  function automatic logic [17:0] memword(input logic [15:0] a);
    if (a == 16'h0000) return 18'h01234;
    return {2'b10, a ^ 16'hA5C3};
  endfunction

  assign imem_ack   = imem_req && ack_en;
  assign imem_rdata = memword(imem_addr);

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_out(pc_out), .pc_plus1(pc_plus1),
    .redirect(redirect), .redirect_addr(redirect_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [17:0] h_instr;
  logic [15:0] h_pc;
  logic [15:0] exp_next;
  logic        p_v, p_rdy, p_rd, p_req, p_ack;
  logic [15:0] p_addr, p_pc, p_ra;
  logic [17:0] p_instr;

  initial begin
    // Asynchronous reset, checked before any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req",   32'(imem_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_pcout", 32'(pc_out), 32'h0);
    chk("rst_addr",  32'(imem_addr), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Zero-wait first fetch
    step();
    chk("c1_req",  32'(imem_req), 32'h1);
    chk("c1_addr", 32'(imem_addr), 32'h0);
    chk("c1_valid", 32'(instr_valid), 32'h0);
    step();
    chk("c2_valid", 32'(instr_valid), 32'h1);
    chk("c2_instr", 32'(instr), 32'h01234);
    chk("c2_pcout", 32'(pc_out), 32'h0);
    chk("c2_pcp1",  32'(pc_plus1), 32'h1);

    // Backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(instr_valid), 32'h1);
      chk("bp_instr", 32'(instr), 32'h01234);
      chk("bp_pcout", 32'(pc_out), 32'h0);
      chk("bp_req",   32'(imem_req), 32'h0);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("acc_addr",  32'(imem_addr), 32'h1);
    chk("acc_req",   32'(imem_req), 32'h1);
    chk("acc_valid", 32'(instr_valid), 32'h0);
    step();
    chk("w1_pcout", 32'(pc_out), 32'h1);
    chk("w1_instr", 32'(instr), 32'(memword(16'h0001)));

    // Redirect in HOLD beats instr_ready
    redirect = 1'b1; redirect_addr = 16'h0040; instr_ready = 1'b1;
    step();
    redirect = 1'b0; instr_ready = 1'b0;
    chk("rdh_valid", 32'(instr_valid), 32'h0);
    chk("rdh_addr",  32'(imem_addr), 32'h0040);
    step();
    chk("rdh_pcout", 32'(pc_out), 32'h0040);
    chk("rdh_instr", 32'(instr), 32'(memword(16'h0040)));

    // Redirect in FETCH with a slow ack
    redirect = 1'b1; redirect_addr = 16'h0005; ack_en = 1'b0;
    step();
    chk("f5_addr", 32'(imem_addr), 32'h0005);
    redirect_addr = 16'h0100;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("fl_addr",  32'(imem_addr), 32'h0005);
      chk("fl_req",   32'(imem_req), 32'h1);
      chk("fl_valid", 32'(instr_valid), 32'h0);
      step();
    end
    chk("fl_addr3", 32'(imem_addr), 32'h0005);
    ack_en = 1'b1;
    step();
    chk("fl_valid_drop", 32'(instr_valid), 32'h0);
    chk("fl_newaddr",    32'(imem_addr), 32'h0100);
    step();
    chk("fl_valid1", 32'(instr_valid), 32'h1);
    chk("fl_pcout",  32'(pc_out), 32'h0100);
    chk("fl_instr",  32'(instr), 32'(memword(16'h0100)));

    // Address wrap
    redirect = 1'b1; redirect_addr = 16'hFFFF;
    step();
    redirect = 1'b0;
    step();
    chk("wr_pcout", 32'(pc_out), 32'hFFFF);
    chk("wr_pcp1",  32'(pc_plus1), 32'h0000);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("wr_addr", 32'(imem_addr), 32'h0000);
    chk("wr_req",  32'(imem_req), 32'h1);
    step();

    // Reset mid-FETCH, between edges
    redirect = 1'b1; redirect_addr = 16'h0300; ack_en = 1'b0;
    step();
    redirect = 1'b0;
    step();
    chk("mr_pre_addr", 32'(imem_addr), 32'h0300);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_req",   32'(imem_req), 32'h0);
    chk("mr_valid", 32'(instr_valid), 32'h0);
    ack_en = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("mr_first_req",  32'(imem_req), 32'h1);
    chk("mr_first_addr", 32'(imem_addr), 32'h0000);

    // Random phase against a program-order model: every delivered instruction
    // must be the successor of the last accepted one or the last redirect target.
    exp_next = 16'h0000;
    for (int n = 0; n < 3000; n++) begin
      ack_en        = ($urandom_range(0, 9) < 6);
      instr_ready   = ($urandom_range(0, 9) < 5);
      redirect      = ($urandom_range(0, 9) == 0);
      redirect_addr = 16'($urandom);
      #1;
      p_v = instr_valid; p_rdy = instr_ready; p_rd = redirect; p_ra = redirect_addr;
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      p_instr = instr; p_pc = pc_out;
      if (p_rd) exp_next = p_ra;
      else if (p_v && p_rdy) exp_next = p_pc + 16'd1;
      @(posedge clk);
      #1;
      chk("rnd_excl", 32'(instr_valid ^ imem_req), 32'h1);
      if (p_req && !p_ack) begin
        chk("rnd_req_hold",  32'(imem_req), 32'h1);
        chk("rnd_addr_hold", 32'(imem_addr), 32'(p_addr));
      end
      if (p_v && p_rd) chk("rnd_rd_drop", 32'(instr_valid), 32'h0);
      if (p_v && !p_rdy && !p_rd) begin
        chk("rnd_bp_valid", 32'(instr_valid), 32'h1);
        chk("rnd_bp_instr", 32'(instr), 32'(p_instr));
        chk("rnd_bp_pc",    32'(pc_out), 32'(p_pc));
      end
      if (!p_v && instr_valid) begin
        h_pc = pc_out; h_instr = instr;
        chk("rnd_pc",    32'(h_pc), 32'(exp_next));
        chk("rnd_instr", 32'(h_instr), 32'(memword(exp_next)));
        chk("rnd_pcp1",  32'(pc_plus1), 32'(exp_next + 16'd1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
